nios_debug_ocimem_ctrl: RTL
===========================

Name: nios_debug_ocimem_ctrl

Overview:
- Debug monitor memory controller directly downstream of the Nios II debug-slave JTAG wrapper.
- Consumes the wrapper's `jdo` and `take_*_ocimem_*` pulses. Produces `MonDReg`, which feeds back into the wrapper's scan chain.
- Owns a single-port debug RAM. The RAM is shared by JTAG-initiated accesses and CPU Avalon-MM slave accesses; JTAG has priority.

Parameters:
- ADDR_W, 8, word-address width of the debug RAM.
- DEPTH, 256, RAM depth in 32-bit words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  JTAG data-out word from the sysclk stage
- take_action_ocimem_a  in  1  pulse: load address, optional read
- take_no_action_ocimem_a  in  1  pulse: streaming read at MonAReg, then increment
- take_action_ocimem_b  in  1  pulse: write jdo[34:3] at MonAReg, then increment
- MonDReg  out  32  last JTAG read data, returned to the JTAG wrapper
- MonAReg  out  ADDR_W  current JTAG word address
- jtag_cmd_overflow  out  1  sticky: a JTAG command was dropped
- address  in  ADDR_W  Avalon word address
- read  in  1  Avalon read
- write  in  1  Avalon write
- writedata  in  32  Avalon write data
- byteenable  in  4  Avalon byte enables
- debugaccess  in  1  CPU is in debug mode; required for Avalon access
- readdata  out  32  Avalon read data
- waitrequest  out  1  Avalon stall

Behaviour:
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous, active-low.
- Reset values: MonDReg=0, MonAReg=0, readdata=0, jtag_cmd_overflow=0, pending=0, FSM=IDLE. RAM contents are not reset.
- FSM states: IDLE, J_RD, J_WR, A_RD, A_WR, A_DONE.
- Command decode, at the cycle T the pulse is seen:
  - action_a: MonAReg <= jdo[17+ADDR_W-1:17]. If jdo[35]=1, a read at the new address follows.
  - no_action_a: read at MonAReg.
  - action_b: write jdo[34:3] at MonAReg.
- JTAG read: IDLE -> J_RD at T+1, RAM address driven. At T+2: MonDReg <= RAM data; MonAReg+1 for no_action_a only; FSM -> IDLE.
- JTAG write: IDLE -> J_WR at T+1. RAM[MonAReg] written at the T+2 edge, all bytes. MonAReg+1. FSM -> IDLE.
- MonAReg wraps DEPTH-1 -> 0.
- Pulses are one-hot by contract. If more than one is seen in a cycle, priority is action_b > action_a > no_action_a; the others are dropped and jtag_cmd_overflow set.
- JTAG command arriving while the FSM is not IDLE: latched into a one-deep pending slot (command type plus jdo fields) and serviced on the next IDLE cycle. Serviced before any Avalon request.
- Command arriving while pending is full: dropped; jtag_cmd_overflow <= 1 (sticky until reset).
- Avalon access is accepted only in IDLE with no JTAG pulse and no pending command that cycle.
  - Read: IDLE -> A_RD -> A_DONE. readdata registered in A_DONE.
  - Write: IDLE -> A_WR -> A_DONE. Byte-enabled write at the A_WR exit edge.
- Avalon latency: waitrequest is combinational = (read|write) & (state != A_DONE). A lone access stalls exactly 2 cycles and completes in the third. The master holds its signals until waitrequest=0.
- debugaccess=0: a write is acknowledged with the normal timing, but the RAM is not modified. A read returns readdata=0.
- read and write both high: treated as a read.
- Reset mid-operation: the FSM returns to IDLE. An uncommitted RAM write (reset before its edge) is not performed. Pending is cleared.

Test Plan:
- Reset, then action_a with jdo[35]=1 and addr=0x10 at cycle 5 -> MonAReg=0x10 at cycle 6; MonDReg=RAM[0x10] at cycle 7.
- MonAReg=0xFF, action_b with data 0xDEADBEEF -> RAM[0xFF]=0xDEADBEEF; MonAReg=0x00. A following no_action_a at 0 reads RAM[0] and MonAReg=0x01.
- Avalon write 0x12345678 to addr 3 with byteenable=4'b0010, debugaccess=1, onto prior RAM[3]=0 -> waitrequest high 2 cycles; RAM[3]=0x00005600. Same access with debugaccess=0 -> RAM[3] unchanged.
- Avalon read at addr 3 held while an action_a pulse arrives in the same cycle -> JTAG serviced first. Avalon waitrequest extends by 2 cycles, then readdata=0x00005600.
- During J_RD, issue action_b, then no_action_a -> action_b is latched into pending and executes after J_RD; no_action_a is dropped and jtag_cmd_overflow=1.
- Assert reset_n low during J_WR -> RAM target unchanged; MonAReg=0, FSM=IDLE, waitrequest=0.

Source files
------------

// File: rtl/nios_debug_ocimem_ctrl.sv
// nios_debug_ocimem_ctrl
// Debug monitor memory controller behind the Nios II debug-slave JTAG wrapper.
// Owns a single-port debug RAM. JTAG commands (take_* pulses + jdo) and CPU
// Avalon-MM slave accesses share it. JTAG always wins.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   jdo, take_*_ocimem_*       JTAG command word and one-cycle command pulses
//   MonDReg, MonAReg           JTAG read data / current JTAG word address
//   jtag_cmd_overflow          sticky: a JTAG command was dropped
//   address..debugaccess       Avalon slave request
//   readdata, waitrequest      Avalon slave response
module nios_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_cmd_overflow,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest
);

  typedef enum logic [2:0] {IDLE, J_RD, J_WR, A_RD, A_WR, A_DONE} state_t;
  typedef enum logic [1:0] {C_NONE, C_A, C_NA, C_B} cmd_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [31:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ovf_q, ovf_d;
  logic              rd_inc_q, rd_inc_d;   // current J_RD came from no_action_a
  logic [31:0]       wdat_q, wdat_d;       // data for the current J_WR
  // pending slot: only jdo[35:3] carries meaning for any command
  logic              pend_vld_q, pend_vld_d;
  cmd_t              pend_typ_q, pend_typ_d;
  logic [35:3]       pend_f_q, pend_f_d;

  cmd_t        in_cmd, run_cmd;
  logic [35:3] run_f;
  logic        multi;
  logic        unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // one-hot violation: keep the highest priority pulse, flag the rest
  assign multi = (take_action_ocimem_b & take_action_ocimem_a) |
                 (take_action_ocimem_b & take_no_action_ocimem_a) |
                 (take_action_ocimem_a & take_no_action_ocimem_a);

  always_comb begin
    in_cmd = C_NONE;
    if      (take_action_ocimem_b)    in_cmd = C_B;
    else if (take_action_ocimem_a)    in_cmd = C_A;
    else if (take_no_action_ocimem_a) in_cmd = C_NA;
  end

  always_comb begin
    state_d    = state_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    rdata_d    = rdata_q;
    ovf_d      = ovf_q | multi;
    rd_inc_d   = rd_inc_q;
    wdat_d     = wdat_q;
    pend_vld_d = pend_vld_q;
    pend_typ_d = pend_typ_q;
    pend_f_d   = pend_f_q;
    run_cmd    = C_NONE;
    run_f      = jdo[35:3];

    // A full slot drops any new command, even in IDLE where the slot drains
    // this cycle: the older command keeps its place in line.
    if (pend_vld_q) begin
      if (in_cmd != C_NONE) ovf_d = 1'b1;
      if (state_q == IDLE) begin
        run_cmd    = pend_typ_q;
        run_f      = pend_f_q;
        pend_vld_d = 1'b0;
      end
    end else if (in_cmd != C_NONE) begin
      if (state_q == IDLE) begin
        run_cmd = in_cmd;
      end else begin
        pend_vld_d = 1'b1;
        pend_typ_d = in_cmd;
        pend_f_d   = jdo[35:3];
      end
    end

    unique case (state_q)
      IDLE: begin
        unique case (run_cmd)
          C_A: begin
            mon_a_d  = run_f[17 +: ADDR_W];
            rd_inc_d = 1'b0;
            if (run_f[35]) state_d = J_RD;
          end
          C_NA: begin
            rd_inc_d = 1'b1;
            state_d  = J_RD;
          end
          C_B: begin
            wdat_d  = run_f[34:3];
            state_d = J_WR;
          end
          default: begin
            // read wins when both strobes are high
            if (read)       state_d = A_RD;
            else if (write) state_d = A_WR;
          end
        endcase
      end
      J_RD: begin
        mon_d_d = mem[mon_a_q];
        if (rd_inc_q) mon_a_d = mon_a_q + ONE;
        state_d = IDLE;
      end
      J_WR: begin
        mon_a_d = mon_a_q + ONE;
        state_d = IDLE;
      end
      A_RD: begin
        rdata_d = debugaccess ? mem[address] : 32'h0;
        state_d = A_DONE;
      end
      A_WR:    state_d = A_DONE;
      A_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      rdata_q    <= '0;
      ovf_q      <= 1'b0;
      rd_inc_q   <= 1'b0;
      wdat_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_typ_q <= C_NONE;
      pend_f_q   <= '0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      rdata_q    <= rdata_d;
      ovf_q      <= ovf_d;
      rd_inc_q   <= rd_inc_d;
      wdat_q     <= wdat_d;
      pend_vld_q <= pend_vld_d;
      pend_typ_q <= pend_typ_d;
      pend_f_q   <= pend_f_d;
    end
  end

  // Writes are keyed off the registered state, so a reset that lands before
  // the commit edge forces IDLE and the write never happens.
  always_ff @(posedge clk) begin
    if (state_q == J_WR) begin
      mem[mon_a_q] <= wdat_q;
    end else if (state_q == A_WR && debugaccess) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem[address][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  assign MonDReg           = mon_d_q;
  assign MonAReg           = mon_a_q;
  assign jtag_cmd_overflow = ovf_q;
  assign readdata          = rdata_q;
  assign waitrequest       = (read | write) & (state_q != A_DONE);

endmodule
